tt_um_pwm_generator_verilog: RTL and testbench



---
 rtl/tt_um_pwm_generator_verilog.sv | 109 ++++++++++
 tb/tb_tt_um_pwm_generator_verilog.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tt_um_pwm_generator_verilog.sv
// Fixed-period PWM generator whose duty is stepped by two debounced push buttons.
// A shadow duty register makes new duty values take effect only at a period start.
module tt_um_pwm_generator_verilog #(
    parameter int PERIOD       = 10,
    parameter int INIT_DUTY    = 5,
    parameter int STEP         = 1,
    parameter int DEBOUNCE_DIV = 2,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ui_increase_duty,
    input  logic ui_decrease_duty,
    output logic uo_PWM_OUT
);

    localparam int DIV_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT_DUTY);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEBOUNCE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // Bit 0 carries the increase button, bit 1 the decrease button.
    logic [1:0] btnRaw;
    logic [1:0] syncA_q, syncB_q;
    logic [1:0] histNew_q, histNew_d;
    logic [1:0] histOld_q, histOld_d;
    logic [1:0] deb_q, deb_d;
    logic [1:0] debPrev_q;
    logic [1:0] press;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sampleEn;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pwm_q, pwm_d;

    assign btnRaw   = {ui_decrease_duty, ui_increase_duty};
    assign sampleEn = (div_q == DIV_LAST);
    assign press    = deb_q & ~debPrev_q;

    always_comb begin
        div_d = sampleEn ? '0 : div_q + DIV_ONE;
    end

    // The level only changes once two consecutive samples agree; otherwise it holds.
    always_comb begin
        histNew_d = histNew_q;
        histOld_d = histOld_q;
        if (sampleEn) begin
            histNew_d = syncB_q;
            histOld_d = histNew_q;
        end
        deb_d = (histNew_q & histOld_q) | (deb_q & (histNew_q | histOld_q));
    end

    // Simultaneous presses cancel; results saturate at 0 and PERIOD.
    always_comb begin
        duty_d = duty_q;
        if (press[0] && !press[1]) begin
            duty_d = (duty_q >= PERIOD_C - STEP_C) ? PERIOD_C : duty_q + STEP_C;
        end else if (press[1] && !press[0]) begin
            duty_d = (duty_q <= STEP_C) ? '0 : duty_q - STEP_C;
        end
    end

    always_comb begin
        cnt_d    = (cnt_q == LAST_C) ? '0 : cnt_q + ONE_C;
        shadow_d = (cnt_q == LAST_C) ? duty_q : shadow_q;
        pwm_d    = (cnt_q < shadow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA_q   <= '0;
            syncB_q   <= '0;
            histNew_q <= '0;
            histOld_q <= '0;
            deb_q     <= '0;
            debPrev_q <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            duty_q    <= INIT_C;
            shadow_q  <= INIT_C;
            pwm_q     <= 1'b0;
        end else begin
            syncA_q   <= btnRaw;
            syncB_q   <= syncA_q;
            histNew_q <= histNew_d;
            histOld_q <= histOld_d;
            deb_q     <= deb_d;
            debPrev_q <= deb_q;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            shadow_q  <= shadow_d;
            pwm_q     <= pwm_d;
        end
    end

    assign uo_PWM_OUT = pwm_q;

endmodule

// File: tb/tb_tt_um_pwm_generator_verilog.sv
// Directed bench for the button-controlled PWM generator; expected waveforms
// are derived from the duty value each step should have reached.
module tb_tt_um_pwm_generator_verilog;

    logic clk;
    logic rst_n;
    logic incBtn;
    logic decBtn;
    logic pwmOut;

    int total = 0;
    int bad   = 0;
    int edgeCnt;

    tt_um_pwm_generator_verilog dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ui_increase_duty (incBtn),
        .ui_decrease_duty (decBtn),
        .uo_PWM_OUT       (pwmOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge k after reset release shows the output for counter value (k-1) mod 10.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edgeCnt <= 0;
        else        edgeCnt <= edgeCnt + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit inc, input bit dec, input int highCycles, input int lowCycles);
        @(negedge clk);
        incBtn = inc;
        decBtn = dec;
        repeat (highCycles) @(negedge clk);
        incBtn = 1'b0;
        decBtn = 1'b0;
        repeat (lowCycles) @(negedge clk);
    endtask

    // Aligns to a period start, then captures one full period of the output.
    task automatic checkPeriod(input string tag, input int expDuty);
        logic [9:0] obsPat;
        logic [9:0] expPat;
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while ((edgeCnt % 10 != 0) && (guard < 25));
        checkOutput({tag, "_align"}, int'(guard < 25), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            obsPat[i] = pwmOut;
            expPat[i] = (i < expDuty);
        end
        checkOutput(tag, int'(obsPat), int'(expPat));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n  = 1'b0;
        incBtn = 1'b0;
        decBtn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pwm_low", int'(pwmOut), 0);
        rst_n = 1'b1;

        checkPeriod("idle_5_a", 5);
        checkPeriod("idle_5_b", 5);

        applyStimulus(1'b1, 1'b0, 10, 30);
        checkPeriod("inc_to_6", 6);
        applyStimulus(1'b1, 1'b0, 10, 30);
        checkPeriod("inc_to_7", 7);
        applyStimulus(1'b1, 1'b0, 10, 30);
        checkPeriod("inc_to_8", 8);
        checkPeriod("inc_to_8_again", 8);

        applyStimulus(1'b0, 1'b1, 10, 30);
        checkPeriod("dec_to_7", 7);
        applyStimulus(1'b0, 1'b1, 10, 30);
        checkPeriod("dec_to_6", 6);
        applyStimulus(1'b0, 1'b1, 10, 30);
        checkPeriod("dec_to_5", 5);

        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 10, 10);
        repeat (20) @(negedge clk);
        checkPeriod("sat_high", 10);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 10, 10);
        repeat (20) @(negedge clk);
        checkPeriod("sat_low", 0);
        applyStimulus(1'b0, 1'b1, 10, 30);
        checkPeriod("below_zero", 0);

        doReset();
        applyStimulus(1'b1, 1'b0, 1, 30);
        checkPeriod("glitch_ignored", 5);
        applyStimulus(1'b1, 1'b1, 10, 30);
        checkPeriod("both_cancel", 5);
        applyStimulus(1'b1, 1'b0, 50, 30);
        checkPeriod("held_one_step", 6);

        applyStimulus(1'b1, 1'b0, 10, 10);
        applyStimulus(1'b1, 1'b0, 10, 30);
        checkPeriod("pre_reset_8", 8);

        // Counter value 2 is on the output here, which is high for duty 8.
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while ((edgeCnt % 10 != 3) && (guard < 25));
        checkOutput("midreset_align", int'(guard < 25), 1);
        #1;
        checkOutput("midreset_high_before", int'(pwmOut), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_async_low", int'(pwmOut), 0);
        @(negedge clk);
        checkOutput("midreset_held_low", int'(pwmOut), 0);
        rst_n = 1'b1;
        checkPeriod("after_reset_5_a", 5);
        checkPeriod("after_reset_5_b", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
